// File: rtl/eb_stream_feeder_pkg.sv
// rtl/eb_stream_feeder_pkg.sv - OpCodes package: EB opcodes, lane geometry, feeder latencies and FSM states
package OpCodes;

  localparam int NSIG          = 15;
  localparam int REGLD_PER_CLK = 4;

  localparam int EB_EXEC_LAT  = 3;
  localparam int EB_STORE_LAT = 1;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_MOV = 4'd7
  } opcode;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } eb_feed_state_t;

endpackage

// File: rtl/eb_stream_feeder_timer.sv
// rtl/eb_stream_feeder_timer.sv - eb_lat_timer: loadable down-counter with zero flag, shared by EXEC and DRAIN
module eb_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/eb_stream_feeder.sv
// rtl/eb_stream_feeder.sv - one-job-in-flight EB sequencer: stream in, drive EB strobes, stream result out
// Optional perf_jobs/perf_stall counters under EB_STREAM_FEEDER_PERF_EN.
module eb_stream_feeder
  import OpCodes::*;
#(
  parameter int LANES     = REGLD_PER_CLK,
  parameter int NBITS     = NSIG + 1,
  parameter int EXEC_LAT  = EB_EXEC_LAT,
  parameter int STORE_LAT = EB_STORE_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data [LANES],
  input  opcode            in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data [LANES],
  output logic [NBITS-1:0] eb_input [LANES],
  output opcode            eb_op,
  output logic             eb_wr_en,
  output logic             eb_feed_data,
  input  logic [NBITS-1:0] eb_result [LANES]
`ifdef EB_STREAM_FEEDER_PERF_EN
  ,
  output logic [31:0]      perf_jobs,
  output logic [31:0]      perf_stall
`endif
);

  localparam int MAX_LAT = (EXEC_LAT > STORE_LAT) ? EXEC_LAT : STORE_LAT;
  localparam int TW      = $clog2(MAX_LAT + 1);

  eb_feed_state_t state;
  opcode          op_q;
  logic           t_load;
  logic           t_zero;
  logic [TW-1:0]  t_value;

  // The timer is armed for EXEC on the way out of LOAD and re-armed for DRAIN on the last EXEC cycle.
  assign t_load  = (state == LOAD) || ((state == EXEC) && t_zero);
  assign t_value = (state == LOAD) ? TW'(EXEC_LAT - 1) : TW'(STORE_LAT - 1);

  eb_lat_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .value (t_value),
    .zero  (t_zero)
  );

  // Strobes decode from registers only, so reset drops them without waiting for a clock.
  assign in_ready     = (state == IDLE) && !rst;
  assign out_valid    = (state == RESP);
  assign eb_feed_data = (state == LOAD);
  assign eb_wr_en     = (state == LOAD) || ((state == EXEC) && t_zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= opcode'('0);
      eb_op    <= opcode'('0);
      eb_input <= '{default: '0};
      out_data <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            eb_input <= in_data;
            op_q     <= in_op;
            state    <= LOAD;
          end
        end
        LOAD: begin
          eb_op <= op_q;
          state <= EXEC;
        end
        EXEC: begin
          if (t_zero) state <= DRAIN;
        end
        DRAIN: begin
          if (t_zero) begin
            out_data <= eb_result;
            state    <= RESP;
          end
        end
        RESP: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EB_STREAM_FEEDER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jobs  <= '0;
      perf_stall <= '0;
    end else if (state == RESP) begin
      if (out_ready) perf_jobs  <= perf_jobs + 32'd1;
      else           perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eb_stream_feeder.sv
// tb/tb_eb_stream_feeder.sv - directed bench for eb_stream_feeder (default latencies and EXEC_LAT=1/STORE_LAT=2)
module tb_eb_stream_feeder;
  import OpCodes::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data [4];
  opcode       in_op;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_wr, a_feed;
  logic [15:0] a_out_data [4];
  logic [15:0] a_eb_input [4];
  logic [15:0] a_res [4];
  opcode       a_eb_op;

  logic        b_in_ready, b_out_valid, b_wr, b_feed;
  logic [15:0] b_out_data [4];
  logic [15:0] b_eb_input [4];
  logic [15:0] b_res [4];
  opcode       b_eb_op;

`ifdef EB_STREAM_FEEDER_PERF_EN
  logic [31:0] a_pj, a_ps, b_pj, b_ps;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  eb_stream_feeder u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .eb_input(a_eb_input), .eb_op(a_eb_op),
    .eb_wr_en(a_wr), .eb_feed_data(a_feed), .eb_result(a_res)
`ifdef EB_STREAM_FEEDER_PERF_EN
    , .perf_jobs(a_pj), .perf_stall(a_ps)
`endif
  );

  eb_stream_feeder #(.EXEC_LAT(1), .STORE_LAT(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .eb_input(b_eb_input), .eb_op(b_eb_op),
    .eb_wr_en(b_wr), .eb_feed_data(b_feed), .eb_result(b_res)
`ifdef EB_STREAM_FEEDER_PERF_EN
    , .perf_jobs(b_pj), .perf_stall(b_ps)
`endif
  );

  // EB stubs: the writeback pulse (wr_en without feed_data) latches lane + op + lane index.
  always_ff @(posedge clk) begin
    if (a_wr && !a_feed)
      for (int i = 0; i < 4; i++) a_res[i] <= a_eb_input[i] + 16'(a_eb_op) + 16'(i);
  end

  always_ff @(posedge clk) begin
    if (b_wr && !b_feed)
      for (int i = 0; i < 4; i++) b_res[i] <= b_eb_input[i] + 16'(b_eb_op) + 16'(i);
  end

  function automatic logic [63:0] pk(input logic [15:0] a [4]);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = a[i];
    return r;
  endfunction

  function automatic logic [63:0] model(input logic [63:0] v, input logic [3:0] op);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = v[16*i +: 16] + 16'(op) + 16'(i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [63:0] v);
    for (int i = 0; i < 4; i++) in_data[i] = v[16*i +: 16];
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(a_in_ready && b_in_ready) && n < 40) begin
      tick();
      n++;
    end
    chk("idle_wait", 64'(a_in_ready && b_in_ready), 64'd1);
  endtask

  // Sample k is taken just after edge E0+k; k=0 is the LOAD cycle.
  task automatic run_job(input logic [63:0] v, input opcode op);
    wait_idle();
    set_vec(v);
    in_op     = op;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      chk($sformatf("A_ctl k%0d", k), 64'({a_feed, a_wr, a_out_valid, a_in_ready}),
          64'({k == 0, k == 0 || k == 3, k == 5, k == 6}));
      chk($sformatf("B_ctl k%0d", k), 64'({b_feed, b_wr, b_out_valid, b_in_ready}),
          64'({k == 0, k == 0 || k == 1, k == 4, k >= 5}));
      if (k == 0) chk("A_load_input", pk(a_eb_input), v);
      if (k == 1) chk("A_exec_op", 64'(a_eb_op), 64'(op));
      if (k == 3) chk("A_input_ignored", pk(a_eb_input), v);
      if (k == 4) chk("B_out_data", pk(b_out_data), model(v, op));
      if (k == 5) chk("A_out_data", pk(a_out_data), model(v, op));
      if (k == 2) begin
        set_vec(~v);
        in_valid = 1'b1;
      end
      if (k == 3) in_valid = 1'b0;
    end
  endtask

  logic [63:0] vs [5];
  logic [63:0] bp_vec;
  int          n, acc, res, last;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = OP_NOP;
    out_ready = 1'b1;
    set_vec(64'd0);
    tick();
    tick();
    chk("in_ready_in_reset", 64'({a_in_ready, b_in_ready}), 64'd0);
    rst = 1'b0;
    tick();

    chk("reset_ctl", 64'({a_feed, a_wr, a_out_valid, a_in_ready}), 64'b0001);
    chk("reset_out_data", pk(a_out_data), 64'd0);
    chk("reset_eb_input", pk(a_eb_input), 64'd0);
    chk("reset_eb_op", 64'(a_eb_op), 64'(OP_NOP));

    // Backpressure: ten stalled RESP cycles, result must stay put.
    bp_vec = 64'h0040_0030_0020_0010;
    set_vec(bp_vec);
    in_op     = OP_SUB;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd5);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("bp_hold %0d", j), 64'({a_out_valid, a_in_ready}), 64'b10);
      chk($sformatf("bp_data %0d", j), pk(a_out_data), model(bp_vec, OP_SUB));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", 64'({a_out_valid, a_in_ready}), 64'b01);
`ifdef EB_STREAM_FEEDER_PERF_EN
    chk("perf_stall", 64'(a_ps), 64'd10);
    chk("perf_jobs", 64'(a_pj), 64'd1);
`endif

    run_job(64'h0004_0003_0002_0001, OP_ADD);
    run_job(64'hFFFF_8000_00FF_1234, OP_XOR);

    // Streaming: in_valid held high, five vectors, one acceptance every 7 cycles.
    vs[0] = 64'h1111_2222_3333_4444;
    vs[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    vs[2] = 64'h0000_0001_0002_0003;
    vs[3] = 64'hDEAD_BEEF_CAFE_F00D;
    vs[4] = 64'h7FFF_FFFE_8001_0100;
    wait_idle();
    out_ready = 1'b1;
    in_op     = OP_MUL;
    set_vec(vs[0]);
    in_valid = 1'b1;
    acc  = 0;
    res  = 0;
    last = 0;
    for (int cyc = 0; cyc < 60 && res < 5; cyc++) begin
      tick();
      if (a_feed) begin
        if (acc > 0) chk($sformatf("stream_period %0d", acc), 64'(cyc - last), 64'd7);
        last = cyc;
        acc++;
        if (acc < 5) set_vec(vs[acc]);
        else in_valid = 1'b0;
      end
      if (a_out_valid) begin
        chk($sformatf("stream_res %0d", res), pk(a_out_data), model(vs[res], OP_MUL));
        res++;
      end
    end
    in_valid = 1'b0;
    chk("stream_counts", 64'({acc[7:0], res[7:0]}), 64'h0505);

    // Reset during the writeback cycle: strobes drop immediately, nothing is presented.
    wait_idle();
    set_vec(64'h0909_0808_0707_0606);
    in_op    = OP_ADD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_wr", 64'(a_wr), 64'd1);
    rst = 1'b1;
    #1;
    chk("reset_async_A", 64'({a_feed, a_wr, a_out_valid, a_in_ready}), 64'd0);
    chk("reset_async_B", 64'({b_feed, b_wr, b_out_valid, b_in_ready}), 64'd0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("post_reset %0d", j), 64'({a_out_valid, a_in_ready, b_out_valid, b_in_ready}),
          64'b0101);
    end
    chk("post_reset_data", pk(a_out_data), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eb_stream_feeder.md
# eb_stream_feeder

Host-side sequencer for the execution block (EB). It takes whole input vectors plus an opcode over a valid/ready stream, then drives EB's `Input_in`, `OP`, `wr_en` and `feed_data`. After a programmed latency it samples EB's `Result_out` and returns each result vector over a second valid/ready stream. It holds one job in flight and sits between the memory/DMA fabric and EB.

## Interface
Parameters:
- `LANES`, default `REGLD_PER_CLK`: vector lanes exchanged with EB per job.
- `NBITS`, default `NSIG+1`: lane width in bits.
- `EXEC_LAT`, default 3: cycles from operand load to ALU writeback in EB (≥1).
- `STORE_LAT`, default 1: cycles from writeback to a valid `Result_out` (≥1).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `in_valid`  in  1  job offered.
- `in_ready`  out  1  job accepted when both high.
- `in_data`  in  LANES×NBITS (unpacked `[NBITS-1:0] [LANES]`)  operand vector.
- `in_op`  in  opcode  operation for the job.
- `out_valid`  out  1  result vector held valid.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  LANES×NBITS  result vector.
- `eb_input`  out  LANES×NBITS  to EB `Input_in`.
- `eb_op`  out  opcode  to EB `OP`.
- `eb_wr_en`  out  1  to EB `wr_en`.
- `eb_feed_data`  out  1  to EB `feed_data`.
- `eb_result`  in  LANES×NBITS  from EB `Result_out`.

## Operation
- State machine `IDLE → LOAD → EXEC → DRAIN → RESP → IDLE`.
- **IDLE:** `in_ready`=1. On `in_valid && in_ready`, latch `in_data` and `in_op`, then go to LOAD. Otherwise hold.
- **LOAD:** lasts 1 cycle. `eb_feed_data`=1, `eb_wr_en`=1, `eb_input`=latched vector. Go to EXEC.
- **EXEC:** lasts `EXEC_LAT` cycles, tracked by a down-counter loaded with `EXEC_LAT-1`.
  - `eb_feed_data`=0 and `eb_op`=latched op.
  - `eb_wr_en`=1 only in the final EXEC cycle (counter==0), for ALU writeback.
- **DRAIN:** lasts `STORE_LAT` cycles with `eb_wr_en`=0. On the edge ending the last DRAIN cycle, capture `eb_result` into `out_data` and go to RESP.
- **RESP:** `out_valid`=1 and `out_data` is stable. On `out_ready`, go to IDLE.
- `in_ready`=0 in every state except IDLE. `in_valid` and `in_data` are ignored outside IDLE.
- `eb_op` holds the last issued opcode between jobs. `eb_input` holds the last loaded vector.
- Data is passed bit-exact; no arithmetic is done on lane data.
- **Reset values:** state=IDLE, counter=0, `out_valid`=0, `out_data`=0, `eb_input`=0, `eb_op`=all-zero encoding, `eb_wr_en`=0, `eb_feed_data`=0.
- `in_ready` is forced to 0 while `rst` is high.
- **Reset mid-job:** the job is abandoned immediately. The EB strobes drop asynchronously and no partial result is ever presented.
- **Back-to-back jobs:** a job offered in the cycle that RESP completes is not accepted until the following IDLE cycle.

## Timing
- Acceptance edge E0. LOAD is the cycle after E0.
- `out_valid` rises `EXEC_LAT+STORE_LAT+2` edges after E0 (6 with defaults).
- The `eb_wr_en` writeback pulse is exactly 1 cycle, `EXEC_LAT+1` edges after E0.
- Minimum job period is `EXEC_LAT+STORE_LAT+3` cycles when `out_ready` is held high.
- Every output is registered or decoded from the state register alone. There is no combinational path from `in_*` or `out_ready` to any output.

## Configuration
- Macro `EB_STREAM_FEEDER_PERF_EN`.
- **Defined:**
  - Adds output port `perf_jobs` (32 bit), incremented on each RESP handshake.
  - Adds output port `perf_stall` (32 bit), incremented each cycle in RESP with `out_ready`=0.
  - Both reset to 0 and wrap at 2^32.
- **Undefined:** both ports and both counters are absent, and behaviour is otherwise identical.

## Structure
- In package `OpCodes`:
  - enum `eb_feed_state_t` (IDLE, LOAD, EXEC, DRAIN, RESP);
  - constants `EB_EXEC_LAT`=3 and `EB_STORE_LAT`=1, used as the parameter defaults.
- Existing package items used: `opcode`, `NSIG`, `REGLD_PER_CLK`.
- One sub-module, `eb_lat_timer`: a loadable down-counter with async reset, a `load` input, a `value` input and a `zero` flag output. It is shared by EXEC and DRAIN.

## Test plan
- **Reset:** assert `rst` mid-EXEC → `eb_wr_en`, `eb_feed_data` and `out_valid` are 0 in the same cycle; after release, `in_ready`=1 and no result ever appears.
- **Single job:** LANES=4, vector {1,2,3,4} with an ADD op, `out_ready` tied to 1.
  - `eb_feed_data`/`eb_wr_en` high for exactly 1 cycle after E0.
  - `eb_wr_en` high again at E0+4.
  - `out_valid` at E0+6, `out_data` equals the stubbed EB's `eb_result`.
- **Backpressure:** hold `out_ready`=0 for 10 cycles → `out_valid` and `out_data` stay stable and `in_ready`=0; with PERF_EN, `perf_stall`=10 and `perf_jobs`=1 after release.
- **Streaming:** `in_valid` constantly high with 5 distinct vectors → one acceptance per 7 cycles and results in order.
- **Ignored input:** toggle `in_data` during EXEC → `eb_input` unchanged.
- **Latency params:** EXEC_LAT=1, STORE_LAT=2 → `eb_wr_en` pulse at E0+2 and `out_valid` at E0+5.
